// File: rtl/barshift_128b_rshift_pipe_if.sv
// Handshake bundle for the pipelined right barrel shifter.
interface barshift_128b_rshift_pipe_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SHW   = 7
);
  logic [WIDTH-1:0] in0;
  logic [SHW-1:0]   in1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic             out_valid;
  logic             out_ready;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in0, in1, in_valid, out_ready,
    input  in_ready, out0, out_valid
  );

  // Shifter side.
  modport slave (
    input  in0, in1, in_valid, out_ready,
    output in_ready, out0, out_valid
  );
endinterface

// File: rtl/barshift_128b_rshift_pipe.sv
// Pipelined right barrel shifter: one log2 step per stage, whole-pipe stall on backpressure.
module barshift_128b_rshift_pipe #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned SHW    = 7,
  parameter bit          ROTATE = 1'b0
) (
  input logic clk,
  input logic rst,
  barshift_128b_rshift_pipe_if.slave bus
);

  logic                       en;
  logic                       accept;
  logic [SHW-1:0][WIDTH-1:0]  data_q;
  logic [SHW-1:0][WIDTH-1:0]  data_nxt;
  logic [SHW-1:0][SHW-1:0]    amt_q;
  logic [SHW-1:0][SHW-1:0]    amt_nxt;
  logic [SHW-1:0]             valid_q;
  logic [SHW-1:0]             valid_nxt;

  // A single enable moves the whole pipe; an empty output slot or a taking consumer frees it.
  assign en     = ~valid_q[SHW-1] | bus.out_ready;
  assign accept = bus.in_valid & en;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned Step = 1 << k;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   src_amt;
    logic             src_valid;

    if (k == 0) begin : g_first
      // Unaccepted inputs are zeroed so nothing undefined enters the pipe.
      assign src       = accept ? bus.in0 : '0;
      assign src_amt   = accept ? bus.in1 : '0;
      assign src_valid = accept;
    end else begin : g_next
      assign src       = data_q[k-1];
      assign src_amt   = amt_q[k-1];
      assign src_valid = valid_q[k-1];
    end

    if (ROTATE) begin : g_rot
      assign shifted = {src[Step-1:0], src[WIDTH-1:Step]};
    end else begin : g_lsr
      assign shifted = {{Step{1'b0}}, src[WIDTH-1:Step]};
    end

    assign data_nxt[k]  = src_amt[k] ? shifted : src;
    assign amt_nxt[k]   = src_amt;
    assign valid_nxt[k] = src_valid;
  end

  // Stage registers: cleared on reset (in-flight items dropped), advance together on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      amt_q   <= '0;
      valid_q <= '0;
    end else if (en) begin
      data_q  <= data_nxt;
      amt_q   <= amt_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out0      = data_q[SHW-1];
  assign bus.out_valid = valid_q[SHW-1];

  // The last stage's shift amount has no consumer.
  logic unused_amt;
  assign unused_amt = ^amt_q[SHW-1];

endmodule

// File: tb/tb_barshift_128b_rshift_pipe.sv
// Bench for the pipelined right shifter: logical and rotate instances share one stimulus.
module tb_barshift_128b_rshift_pipe;
  localparam int unsigned W = 128;
  localparam int unsigned S = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in0;
  logic [S-1:0] in1;
  logic         in_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  barshift_128b_rshift_pipe_if #(.WIDTH(W), .SHW(S)) bl ();
  barshift_128b_rshift_pipe_if #(.WIDTH(W), .SHW(S)) br ();

  assign bl.in0 = in0;
  assign bl.in1 = in1;
  assign bl.in_valid = in_valid;
  assign bl.out_ready = out_ready;
  assign br.in0 = in0;
  assign br.in1 = in1;
  assign br.in_valid = in_valid;
  assign br.out_ready = out_ready;

  barshift_128b_rshift_pipe #(.WIDTH(W), .SHW(S), .ROTATE(1'b0)) u_lsr (
    .clk (clk),
    .rst (rst),
    .bus (bl.slave)
  );

  barshift_128b_rshift_pipe #(.WIDTH(W), .SHW(S), .ROTATE(1'b1)) u_rot (
    .clk (clk),
    .rst (rst),
    .bus (br.slave)
  );

  typedef struct {
    logic [W-1:0] in0;
    logic [S-1:0] in1;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
  } vec_t;

  vec_t         tbl [7];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           fires = 0;
  int           first_fire = 0;
  int           last_fire = 0;
  logic [W-1:0] q_l [$];
  logic [W-1:0] q_r [$];

  function automatic logic [W-1:0] ref_lsr(logic [W-1:0] d, logic [S-1:0] s);
    return d >> s;
  endfunction

  function automatic logic [W-1:0] ref_rot(logic [W-1:0] d, logic [S-1:0] s);
    int unsigned back;
    back = W - int'(s);
    return (d >> s) | (d << back);
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: score handshakes against the model, then advance to #1 past the edge.
  task automatic step();
    logic [W-1:0] e;
    #1;
    check("in_ready_rule", W'(bl.in_ready), W'(!bl.out_valid || out_ready));
    if (bl.out_valid && out_ready) begin
      if (q_l.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_lsr got=%h exp=none", bl.out0);
      end else begin
        e = q_l.pop_front();
        check("stream_lsr", bl.out0, e);
      end
      if (fires == 0) first_fire = cyc;
      fires++;
      last_fire = cyc;
    end
    if (br.out_valid && out_ready) begin
      if (q_r.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_rot got=%h exp=none", br.out0);
      end else begin
        e = q_r.pop_front();
        check("stream_rot", br.out0, e);
      end
    end
    if (in_valid && bl.in_ready) begin
      q_l.push_back(ref_lsr(in0, in1));
      q_r.push_back(ref_rot(in0, in1));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single accept, then wait (bounded) for the result and check its latency.
  task automatic single(input logic [W-1:0] d, input logic [S-1:0] s, output int lat);
    in0 = d;
    in1 = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!bl.out_valid && lat < 30) begin
      step();
      lat++;
    end
    check("latency", W'(lat), W'(7));
  endtask

  initial begin
    int           lat;
    logic [W-1:0] snap;

    tbl[0] = '{128'h80000000_00000000_00000000_00000000, 7'd127,
               128'h1, 128'h1};
    tbl[1] = '{128'hDEADBEEF_01234567_89ABCDEF_0000CAFE, 7'd0,
               128'hDEADBEEF_01234567_89ABCDEF_0000CAFE,
               128'hDEADBEEF_01234567_89ABCDEF_0000CAFE};
    tbl[2] = '{128'hDEADBEEF_01234567_89ABCDEF_0000CAFE, 7'd64,
               128'h00000000_00000000_DEADBEEF_01234567,
               128'h89ABCDEF_0000CAFE_DEADBEEF_01234567};
    tbl[3] = '{128'h1, 7'd1, 128'h0, 128'h80000000_00000000_00000000_00000000};
    tbl[4] = '{128'hF, 7'd2, 128'h3, 128'hC0000000_00000000_00000000_00000003};
    tbl[5] = '{{W{1'b1}}, 7'd127, 128'h1, {W{1'b1}}};
    tbl[6] = '{128'hFF00, 7'd8, 128'hFF, 128'hFF};

    rst = 1'b1;
    in0 = '0;
    in1 = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", W'(bl.out_valid), W'(0));
    check("rst_out0", bl.out0, '0);
    check("rst_in_ready", W'(bl.in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors with known answers.
    for (int i = 0; i < 7; i++) begin
      single(tbl[i].in0, tbl[i].in1, lat);
      check("tbl_lsr", bl.out0, tbl[i].exp_l);
      check("tbl_rot", br.out0, tbl[i].exp_r);
      step();
      check("single_pulse", W'(bl.out_valid), W'(0));
    end

    // Ten back-to-back accepts must emerge as ten consecutive results.
    fires = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in0 = rnd128();
      in1 = S'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    check("b2b_count", W'(fires), W'(10));
    check("b2b_contig", W'(last_fire - first_fire), W'(9));

    // Fill the pipe under backpressure, hold, then retire and refill simultaneously.
    fires = 0;
    out_ready = 1'b0;
    repeat (7) begin
      in0 = rnd128();
      in1 = S'($urandom());
      in_valid = 1'b1;
      step();
    end
    snap = bl.out0;
    in0 = rnd128();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_in_ready", W'(bl.in_ready), W'(0));
      check("stall_valid", W'(bl.out_valid), W'(1));
      check("stall_out0", bl.out0, snap);
    end
    out_ready = 1'b1;
    repeat (5) begin
      in0 = rnd128();
      in1 = S'($urandom());
      step();
    end
    in_valid = 1'b0;
    repeat (15) step();
    check("stall_drained", W'(q_l.size()), W'(0));
    check("stall_count", W'(fires), W'(12));

    // Async reset with a full pipe drops everything.
    out_ready = 1'b0;
    repeat (7) begin
      in0 = rnd128();
      in1 = S'($urandom());
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", W'(bl.out_valid), W'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", W'(bl.out_valid), W'(0));
    check("async_rst_out0", bl.out0, '0);
    @(negedge clk);
    rst = 1'b0;
    q_l.delete();
    q_r.delete();
    @(posedge clk);
    #1;
    fires = 0;
    out_ready = 1'b1;
    repeat (15) step();
    check("no_stale", W'(fires), W'(0));
    single(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 7'd36, lat);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in0 = rnd128();
      in1 = S'($urandom());
      in_valid = ($urandom() % 4) != 0;
      out_ready = ($urandom() % 3) != 0;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    check("rand_drained_lsr", W'(q_l.size()), W'(0));
    check("rand_drained_rot", W'(q_r.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
